ofm_pingpong_buffer: RTL and testbench
======================================

# ofm_pingpong_buffer

Double-buffered (ping-pong) on-chip store for output feature maps ahead of the SE stage. The conv datapath fills one bank while the SE datapath reads the other. Bank ownership is tracked with full flags and a frame-level handshake (`wr_last` / `rd_done`). The read address is scaled by a runtime shift, which generalises the fixed ">>2" packed-read addressing used in the single-bank OFM store.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width of each bank entry.
- `DEPTH`, 100352, entries per bank; two banks are instantiated, inferred as block RAM.
- `ADDR_W`, 20, width of `wr_addr` and `rd_addr`; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `wr_en`  in  1  write request.
- `wr_addr`  in  ADDR_W  word address in the current write bank.
- `data_in`  in  DATA_WIDTH  write data.
- `wr_last`  in  1  qualifies `wr_en`; marks the final word of a frame.
- `wr_ready`  out  1  the write bank is free (not full).
- `wr_bank`  out  1  index of the current write bank.
- `rd_en`  in  1  read request.
- `rd_addr`  in  ADDR_W  raw read address.
- `rd_shift`  in  2  right shift applied to `rd_addr`, range 0..3.
- `rd_done`  in  1  reader releases the current read bank.
- `rd_ready`  out  1  the read bank holds a complete frame.
- `rd_bank`  out  1  index of the current read bank.
- `data_out`  out  DATA_WIDTH  read data, registered.
- `data_valid`  out  1  `data_out` was updated by an accepted read.
- `wr_err`  out  1  sticky: a write was dropped.
- `rd_err`  out  1  sticky: a read was rejected.

## Operation
- State consists of `full[1:0]`, write pointer `wb`, and read pointer `rb`.
- Outputs follow directly: `wr_ready = !full[wb]`, `rd_ready = full[rb]`, `wr_bank = wb`, `rd_bank = rb`.
- **Write acceptance:** a write is accepted when `wr_en && wr_ready && wr_addr < DEPTH`. The bank `wb` entry at `wr_addr` gets `data_in`.
- **Frame end:** an accepted write with `wr_last` high sets `full[wb]` and toggles `wb`.
- **Dropped writes:** a write is dropped when `wr_en` is high and either `!wr_ready` or `wr_addr >= DEPTH`. A drop sets `wr_err` and leaves RAM and state unchanged.
- **Read address:** the effective read address is `ea = rd_addr >> rd_shift`, a logical shift.
- **Read acceptance:** a read is accepted when `rd_en && rd_ready && ea < DEPTH`. On the next edge `data_out` gets bank `rb` entry at `ea` and `data_valid` goes to 1.
- **Rejected reads:** a read is rejected when `rd_en` is high and either `!rd_ready` or `ea >= DEPTH`. A reject sets `rd_err`, drives `data_valid` to 0 and holds `data_out`.
- **Bank release:** `rd_done` while `rd_ready` clears `full[rb]` and toggles `rb`. `rd_done` while `!rd_ready` is ignored; it is not an error.
- **Same-cycle read and release:** a read accepted in the same cycle as `rd_done` is served from the old `rb`; the release takes effect afterwards.
- **Same-cycle write and release:** `wr_last` and `rd_done` in the same cycle always target different banks. Both take effect, and the released bank may become the next write bank.
- **Idle cycles:** with `rd_en` low, `data_valid` is 0 and `data_out` holds its value.
- **Error clearing:** the error flags clear only on reset.
- **Reset:** RAM contents are not cleared. A mid-frame reset abandons both banks: they become empty and stale data is unreadable until refilled.

## Timing
- Reset values: `full = 2'b00`, `wb = 0`, `rb = 0`, `data_out = 0`, `data_valid = 0`, `wr_err = 0`, `rd_err = 0`. It follows that `wr_ready = 1` and `rd_ready = 0`.
- Read latency is 1 cycle, from `rd_en` sampled at edge N to `data_out`/`data_valid` valid after edge N.
- Write data is visible to a read of the same bank only after the bank is handed over. This needs at least one edge after the `wr_last` write; `rd_ready` rises on that edge.
- Throughput is one write and one read per cycle, concurrently on different banks.
- Flags and pointers update on the same edge as the triggering request. `wr_ready`/`rd_ready` are combinational from registered state only.

## Test plan
- **Reset:** hold `rst_n = 0` for 3 cycles. Required: `wr_ready = 1`, `rd_ready = 0`, `data_out = 0`, both errors 0.
- **Single frame:** write bank 0, addresses 0..7 with data `0xA0..0xA7`, `wr_last` on address 7. Required: `wr_bank = 1`, `rd_ready = 1`. Then read with `rd_shift = 2`, `rd_addr = 12`. Required: `data_out = 0xA3` with `data_valid = 1` one cycle later.
- **Overlap:** fill bank 1 with `0xB*` while reading bank 0, then `rd_done`. Required: `rd_bank = 1`, and a read at `rd_addr = 5`, `rd_shift = 0` returns `0xB5`. Reads issued before the `rd_done` edge return `0xA*`.
- **Both banks full:** after two frames, with no `rd_done`, issue a write. Required: `wr_ready = 0`, the write is dropped, `wr_err = 1`, and bank contents are unchanged on readback.
- **Illegal accesses:** read with `rd_ready = 0`, then read at `rd_addr = DEPTH`, `rd_shift = 0`. Required: `rd_err = 1`, `data_valid = 0`, `data_out` unchanged.
- **Mid-frame reset:** assert reset after 4 writes into bank 0. Required: `rd_ready = 0`, `wb = 0`, and a following 8-word frame reads back correctly.

Source files
------------

// File: rtl/ofm_pingpong_buffer.sv
// Two-bank ping-pong store for output feature maps: the conv side fills one bank while the SE side reads the other.
// Reads complete 1 cycle after acceptance (registered data_out). Writes are committed on the edge that accepts them.
// There is no stall. Writes to a full bank and reads from a bank without a complete frame are dropped and flagged in sticky error bits.
//
// Ports:
//   clk, rst_n                  single rising-edge clock, synchronous active-low reset
//   wr_en/wr_addr/data_in       write request into the current write bank (wr_bank)
//   wr_last                     final word of a frame; hands the write bank over to the reader
//   wr_ready, wr_bank           write bank is empty / index of the write bank
//   rd_en/rd_addr/rd_shift      read request; effective address = rd_addr >> rd_shift
//   rd_done                     reader releases the current read bank
//   rd_ready, rd_bank           read bank holds a complete frame / index of the read bank
//   data_out, data_valid        registered read data and its per-cycle valid strobe
//   wr_err, rd_err              sticky drop/reject flags, cleared only by reset
module ofm_pingpong_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 100352,
    parameter int ADDR_W     = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_last,
    output logic                  wr_ready,
    output logic                  wr_bank,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    input  logic [1:0]            rd_shift,
    input  logic                  rd_done,
    output logic                  rd_ready,
    output logic                  rd_bank,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  wr_err,
    output logic                  rd_err
);

    // RAM index width. Addresses are range-checked at full width before they are narrowed.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Depth is held one bit wider than the address so a DEPTH of 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem0 [DEPTH];
    logic [DATA_WIDTH-1:0] mem1 [DEPTH];

    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wb;
    logic              rb;

    logic [ADDR_W-1:0] ea;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_acc;
    logic              rd_acc;
    logic              wr_frame_end;
    logic              rel;

    assign wr_ready = !full[wb];
    assign rd_ready = full[rb];
    assign wr_bank  = wb;
    assign rd_bank  = rb;

    assign ea          = rd_addr >> rd_shift;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_X;
    assign rd_in_range = {1'b0, ea} < DEPTH_X;
    assign wr_idx      = wr_addr[IDX_W-1:0];
    assign rd_idx      = ea[IDX_W-1:0];

    assign wr_acc       = wr_en && wr_ready && wr_in_range;
    assign rd_acc       = rd_en && rd_ready && rd_in_range;
    assign wr_frame_end = wr_acc && wr_last;
    assign rel          = rd_done && rd_ready;

    // A frame end needs !full[wb] and a release needs full[rb]. When both happen in
    // the same cycle they therefore always hit different banks, so the two updates never collide.
    always_comb begin
        full_nxt = full;
        if (wr_frame_end) full_nxt[wb] = 1'b1;
        if (rel)          full_nxt[rb] = 1'b0;
    end

    // RAM arrays carry no reset so they can map onto block RAM. Writes are held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            if (wb) mem1[wr_idx] <= data_in;
            else    mem0[wr_idx] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full       <= 2'b00;
            wb         <= 1'b0;
            rb         <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            wr_err     <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            full       <= full_nxt;
            if (wr_frame_end) wb <= ~wb;
            if (rel)          rb <= ~rb;
            // Reads use rb from before this edge, so a read that coincides with rd_done is served from the old bank.
            if (rd_acc) data_out <= rb ? mem1[rd_idx] : mem0[rd_idx];
            data_valid <= rd_acc;
            if (wr_en && !wr_acc) wr_err <= 1'b1;
            if (rd_en && !rd_acc) rd_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ofm_pingpong_buffer.sv
module tb_ofm_pingpong_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 100352;
    localparam int AW    = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] data_in;
    logic          wr_last;
    logic          wr_ready;
    logic          wr_bank;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_shift;
    logic          rd_done;
    logic          rd_ready;
    logic          rd_bank;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          wr_err;
    logic          rd_err;

    int n_cmp = 0;
    int n_bad = 0;

    ofm_pingpong_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .data_in    (data_in),
        .wr_last    (wr_last),
        .wr_ready   (wr_ready),
        .wr_bank    (wr_bank),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_shift   (rd_shift),
        .rd_done    (rd_done),
        .rd_ready   (rd_ready),
        .rd_bank    (rd_bank),
        .data_out   (data_out),
        .data_valid (data_valid),
        .wr_err     (wr_err),
        .rd_err     (rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge. Inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; data_in = '0; wr_last = 1'b0;
        rd_en = 1'b0; rd_addr = '0; rd_shift = 2'd0; rd_done = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last);
        wr_en = 1'b1; wr_addr = a; data_in = d; wr_last = last;
        tick();
        wr_en = 1'b0; wr_last = 1'b0;
    endtask

    task automatic wr_frame(input logic [DW-1:0] base);
        for (int i = 0; i < 8; i++) wr(AW'(i), base + DW'(i), i == 7);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [1:0] sh);
        rd_en = 1'b1; rd_addr = a; rd_shift = sh;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        idle_inputs();

        // Reset state
        do_reset(3);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_ready", 32'(rd_ready), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        chk("rst_rd_err", 32'(rd_err), 32'd0);
        chk("rst_banks", {30'd0, wr_bank, rd_bank}, 32'd0);

        // Single frame into bank 0
        wr_frame(32'hA0);
        chk("f1_wr_bank", 32'(wr_bank), 32'd1);
        chk("f1_rd_ready", 32'(rd_ready), 32'd1);
        chk("f1_wr_ready", 32'(wr_ready), 32'd1);
        rd(20'd12, 2'd2);
        chk("f1_rd_shift2", data_out, 32'hA3);
        chk("f1_rd_valid", 32'(data_valid), 32'd1);
        tick();
        chk("idle_valid", 32'(data_valid), 32'd0);
        chk("idle_hold", data_out, 32'hA3);

        // Overlap: fill bank 1 while reading bank 0
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); data_in = 32'hB0 + 32'(i); wr_last = (i == 7);
            rd_en = 1'b1; rd_addr = AW'(i); rd_shift = 2'd0;
            tick();
            chk($sformatf("ovl_rd%0d", i), data_out, 32'hA0 + 32'(i));
        end
        idle_inputs();
        chk("both_full_wr_ready", 32'(wr_ready), 32'd0);
        chk("both_full_wr_bank", 32'(wr_bank), 32'd0);

        // Write with both banks full is dropped
        wr(20'd3, 32'hDEAD, 1'b0);
        chk("drop_wr_err", 32'(wr_err), 32'd1);
        chk("drop_wr_bank", 32'(wr_bank), 32'd0);
        rd(20'd3, 2'd0);
        chk("drop_bank0_intact", data_out, 32'hA3);

        // Read in the same cycle as rd_done is served from the old bank
        rd_en = 1'b1; rd_addr = 20'd6; rd_shift = 2'd0; rd_done = 1'b1;
        tick();
        idle_inputs();
        chk("rel_rd_old_bank", data_out, 32'hA6);
        chk("rel_rd_bank", 32'(rd_bank), 32'd1);
        chk("rel_wr_ready", 32'(wr_ready), 32'd1);
        rd(20'd5, 2'd0);
        chk("bank1_rd5", data_out, 32'hB5);
        chk("rd_err_clean", 32'(rd_err), 32'd0);

        // Release bank 1, then perform illegal reads
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("rel2_rd_bank", 32'(rd_bank), 32'd0);
        chk("rel2_rd_ready", 32'(rd_ready), 32'd0);
        rd(20'd0, 2'd0);
        chk("notready_rd_err", 32'(rd_err), 32'd1);
        chk("notready_valid", 32'(data_valid), 32'd0);
        chk("notready_hold", data_out, 32'hB5);
        wr_frame(32'hC0);
        chk("f3_rd_ready", 32'(rd_ready), 32'd1);
        rd(AW'(DEPTH), 2'd0);
        chk("oor_valid", 32'(data_valid), 32'd0);
        chk("oor_hold", data_out, 32'hB5);
        rd(AW'(4 * (DEPTH - 1)), 2'd2);
        chk("last_entry_valid", 32'(data_valid), 32'd1);
        rd(20'd2, 2'd0);
        chk("f3_rd2", data_out, 32'hC2);

        // Mid-frame reset abandons both banks
        do_reset(2);
        for (int i = 0; i < 4; i++) wr(AW'(i), 32'hD0 + 32'(i), 1'b0);
        chk("mid_wr_bank", 32'(wr_bank), 32'd0);
        do_reset(2);
        chk("mrst_rd_ready", 32'(rd_ready), 32'd0);
        chk("mrst_wr_bank", 32'(wr_bank), 32'd0);
        chk("mrst_errs", {30'd0, wr_err, rd_err}, 32'd0);
        wr_frame(32'hE0);
        chk("f4_rd_ready", 32'(rd_ready), 32'd1);
        rd(20'd4, 2'd0);
        chk("f4_rd4", data_out, 32'hE4);
        rd(20'd28, 2'd2);
        chk("f4_rd7", data_out, 32'hE7);
        rd(20'd0, 2'd0);
        chk("f4_rd0", data_out, 32'hE0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
